mux_burst_arbiter: RTL and testbench

- Two-requester burst arbiter that owns the select of a registered 2:1 datapath mux.
- Each requester presents data beats with req_n and marks the final beat with last_n.
- The arbiter grants one requester at a time, steers its data to dout, and releases on last beat, request drop, or burst-length limit.
- Round-robin between requesters, so neither starves; sits in front of any shared single-port sink.

---
 rtl/mux_burst_arbiter.sv | 121 ++++++++++++
 tb/tb_mux_burst_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_burst_arbiter.sv
// Two-requester burst arbiter driving the select of a registered 2:1 data mux.
// Define MUX_BURST_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority to requester 0.
module mux_burst_arbiter #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_0,
    input  logic             last_0,
    input  logic [WIDTH-1:0] din_0,
    input  logic             req_1,
    input  logic             last_1,
    input  logic [WIDTH-1:0] din_1,
    output logic             gnt_0,
    output logic             gnt_1,
    output logic             sel,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid
);

    // Beat counter only has to reach MAX_BURST-1; one bit is kept when unlimited.
    localparam int unsigned CW = (MAX_BURST == 0) ? 1 : $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t          state;
    logic            last_owner;
    logic [CW-1:0]   cnt;

    logic             owner;
    logic             req_own;
    logic             last_own;
    logic [WIDTH-1:0] din_own;
    logic             req_other;
    logic             accept;
    logic             at_limit;
    logic             release_now;
    logic             go_other;
    logic             pick;

    // Decode of the current owner's handshake and the release decision.
    always_comb begin
        owner       = (state == GRANT1);
        req_own     = owner ? req_1  : req_0;
        last_own    = owner ? last_1 : last_0;
        din_own     = owner ? din_1  : din_0;
        req_other   = owner ? req_0  : req_1;
        accept      = (state != IDLE) && req_own;
        at_limit    = (MAX_BURST != 0) && (cnt == CW'(MAX_BURST - 1));
        release_now = (state != IDLE) && (!req_own || last_own || at_limit);
`ifdef MUX_BURST_ARB_FIXED_PRIO_EN
        // Requester 0 still asking after its own release goes back via IDLE, where it wins again.
        go_other    = req_other && !((state == GRANT0) && req_0);
        pick        = !req_0;
`else
        go_other    = req_other;
        pick        = (req_0 && req_1) ? ~last_owner : req_1;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            cnt        <= '0;
            gnt_0      <= 1'b0;
            gnt_1      <= 1'b0;
            sel        <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= accept;
            if (accept) begin
                dout <= din_own;
            end

            case (state)
                IDLE: begin
                    if (req_0 || req_1) begin
                        state      <= pick ? GRANT1 : GRANT0;
                        last_owner <= pick;
                        cnt        <= '0;
                        gnt_0      <= ~pick;
                        gnt_1      <= pick;
                        sel        <= pick;
                    end
                end
                GRANT0, GRANT1: begin
                    if (release_now) begin
                        if (go_other) begin
                            // Direct handover: the other requester owns the mux on the next edge.
                            state      <= owner ? GRANT0 : GRANT1;
                            last_owner <= ~owner;
                            cnt        <= '0;
                            gnt_0      <= owner;
                            gnt_1      <= ~owner;
                            sel        <= ~owner;
                        end else begin
                            state <= IDLE;
                            gnt_0 <= 1'b0;
                            gnt_1 <= 1'b0;
                        end
                    end else if (accept && (MAX_BURST != 0)) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt_0 <= 1'b0;
                    gnt_1 <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_burst_arbiter.sv
// Self-checking bench for mux_burst_arbiter: directed scenarios plus random traffic
// compared cycle by cycle against an owner/beat-count reference model.
module tb_mux_burst_arbiter;

    localparam int unsigned WIDTH = 8;
    localparam int          MAXB  = 4;
`ifdef MUX_BURST_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             rq [2];
    logic             ls [2];
    logic [WIDTH-1:0] dn [2];
    logic             gnt_0, gnt_1, sel, dout_valid;
    logic [WIDTH-1:0] dout;

    int tests = 0;
    int fails = 0;

    // Reference model: who owns the mux, beats taken this grant, last winner.
    int               m_owner = -1;
    int               m_cnt   = 0;
    int               m_last  = 1;
    bit               m_sel   = 1'b0;
    bit               m_dv    = 1'b0;
    logic [WIDTH-1:0] m_dout  = '0;
    bit               acc [2];
    int               rem [2];

    mux_burst_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAXB)) dut (
        .clk(clk), .reset(rst),
        .req_0(rq[0]), .last_0(ls[0]), .din_0(dn[0]),
        .req_1(rq[1]), .last_1(ls[1]), .din_1(dn[1]),
        .gnt_0(gnt_0), .gnt_1(gnt_1), .sel(sel),
        .dout(dout), .dout_valid(dout_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH+3:0] exp_v();
        return {(m_owner == 1), (m_owner == 0), m_sel, m_dv, m_dout};
    endfunction

    function automatic logic [WIDTH+3:0] obs_v();
        return {gnt_1, gnt_0, sel, dout_valid, dout};
    endfunction

    // Advance the model by one edge using the inputs the DUT sees at that edge.
    task automatic model_edge();
        int o;
        bit done;
        acc[0] = 1'b0;
        acc[1] = 1'b0;
        if (rst) begin
            m_owner = -1; m_cnt = 0; m_last = 1; m_sel = 1'b0; m_dout = '0; m_dv = 1'b0;
            return;
        end
        m_dv = 1'b0;
        if (m_owner < 0) begin
            if (rq[0] || rq[1]) begin
                if (rq[0] && rq[1]) o = FIXED ? 0 : 1 - m_last;
                else                o = rq[0] ? 0 : 1;
                m_owner = o; m_last = o; m_cnt = 0; m_sel = (o == 1);
            end
        end else begin
            o = m_owner;
            if (rq[o]) begin
                acc[o] = 1'b1;
                m_dout = dn[o];
                m_dv   = 1'b1;
                m_cnt++;
                done = ls[o] || (MAXB != 0 && m_cnt == MAXB);
            end else begin
                done = 1'b1;
            end
            if (done) begin
                if (rq[1-o] && !(FIXED && o == 0 && rq[0])) begin
                    m_owner = 1 - o; m_last = 1 - o; m_cnt = 0; m_sel = (o == 0);
                end else begin
                    m_owner = -1;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic quiet_inputs();
        for (int n = 0; n < 2; n++) begin
            rq[n] = 1'b0; ls[n] = 1'b0; dn[n] = '0; rem[n] = 0;
        end
    endtask

    // Random requesters: bursts of minl..maxl beats, each cycle valid with probability p%.
    task automatic drive_reqs(input int p, input int minl, input int maxl, input bit nolast);
        for (int n = 0; n < 2; n++) begin
            if (acc[n]) begin
                rem[n]--;
                dn[n] = WIDTH'($urandom);
            end
            if (rem[n] <= 0) rem[n] = int'($urandom_range(minl, maxl));
            rq[n] = (int'($urandom_range(0, 99)) < p);
            ls[n] = rq[n] ? (!nolast && rem[n] == 1) : 1'($urandom);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int n = 0; n < 2; n++) begin
            rq[n] = 1'($urandom); ls[n] = 1'($urandom); dn[n] = WIDTH'($urandom);
        end
        for (int c = 0; c < 2; c++) begin
            tick();
            tests++;
            if (obs_v() !== '0) begin
                fails++;
                $display("FAIL reset_values: got %h, want 0", obs_v());
            end
        end
        rst = 1'b0;
        quiet_inputs();
    endtask

    task automatic test_single_burst();
        logic [WIDTH-1:0] beats [3];
        beats[0] = 8'h11; beats[1] = 8'h22; beats[2] = 8'h33;
        do_reset();
        rq[0] = 1'b1; ls[0] = 1'b0; dn[0] = beats[0];
        for (int c = 1; c <= 5; c++) begin
            tick();
            tests++;
            if (gnt_0 !== (c <= 3) || dout_valid !== (c >= 2 && c <= 4) ||
                (c >= 2 && c <= 4 && dout !== beats[c-2])) begin
                fails++;
                $display("FAIL single_burst c%0d: gnt_0=%b dv=%b dout=%h", c, gnt_0, dout_valid, dout);
            end
            tests++;
            if (obs_v() !== exp_v()) begin
                fails++;
                $display("FAIL single_model c%0d: got %h, want %h", c, obs_v(), exp_v());
            end
            if (c == 2) dn[0] = beats[1];
            if (c == 3) begin dn[0] = beats[2]; ls[0] = 1'b1; end
            if (c == 4) begin rq[0] = 1'b0; ls[0] = 1'b0; end
        end
    endtask

    task automatic test_round_robin();
        int  seq [$];
        bit  p0 = 1'b0, p1 = 1'b0, seen_dv = 1'b0;
        do_reset();
        quiet_inputs();
        drive_reqs(100, 2, 2, 1'b0);
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (gnt_0 && !p0) seq.push_back(0);
            if (gnt_1 && !p1) seq.push_back(1);
            p0 = gnt_0; p1 = gnt_1;
            tests++;
            if (obs_v() !== exp_v() || ((gnt_0 || gnt_1) && sel !== gnt_1) ||
                (!FIXED && seen_dv && dout_valid !== 1'b1)) begin
                fails++;
                $display("FAIL round_robin c%0d: got %h, want %h", c, obs_v(), exp_v());
            end
            if (dout_valid === 1'b1) seen_dv = 1'b1;
            drive_reqs(100, 2, 2, 1'b0);
        end
        tests++;
        if (seq.size() < 4) begin
            fails++;
            $display("FAIL rr_grant_count: got %0d, want >= 4", seq.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                tests++;
                if (seq[k] != (FIXED ? 0 : k % 2)) begin
                    fails++;
                    $display("FAIL rr_order[%0d]: got %0d, want %0d", k, seq[k], FIXED ? 0 : k % 2);
                end
            end
        end
        quiet_inputs();
    endtask

    task automatic test_burst_limit();
        int k1 = 0, from1 = 0, fall_c = -1;
        bit p1 = 1'b0;
        do_reset();
        quiet_inputs();
        rq[1] = 1'b1; dn[1] = 8'hA0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (dout_valid === 1'b1 && dout[7:4] === 4'hA) from1++;
            if (p1 && !gnt_1) begin
                fall_c = c;
                tests++;
                if (gnt_0 !== 1'b1) begin
                    fails++;
                    $display("FAIL limit_handover: gnt_0=%b, want 1", gnt_0);
                end
            end
            p1 = gnt_1;
            tests++;
            if (obs_v() !== exp_v()) begin
                fails++;
                $display("FAIL limit_model c%0d: got %h, want %h", c, obs_v(), exp_v());
            end
            if (acc[1]) begin k1++; dn[1] = WIDTH'(8'hA0 + k1); end
            rq[1] = (k1 < 10);
            rq[0] = 1'b1; dn[0] = 8'h50;
        end
        tests++;
        if (from1 != MAXB || fall_c != MAXB + 1) begin
            fails++;
            $display("FAIL limit_beats: got %0d beats fall at %0d, want %0d at %0d", from1, fall_c, MAXB, MAXB + 1);
        end
        quiet_inputs();
    endtask

    task automatic test_req_drop();
        do_reset();
        quiet_inputs();
        rq[0] = 1'b1; dn[0] = 8'h3C;
        for (int c = 1; c <= 5; c++) begin
            tick();
            tests++;
            if (obs_v() !== exp_v() ||
                (c == 4 && (gnt_0 !== 1'b0 || dout_valid !== 1'b0)) ||
                (c == 5 && gnt_0 !== 1'b1)) begin
                fails++;
                $display("FAIL req_drop c%0d: got %h, want %h", c, obs_v(), exp_v());
            end
            dn[0] = WIDTH'($urandom);
            rq[0] = (c != 3);
        end
        quiet_inputs();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        quiet_inputs();
        rq[0] = 1'b1; dn[0] = 8'h01;
        tick();
        tick();
        dn[0] = 8'h02;
        rst = 1'b1;
        tick();
        tests++;
        if (obs_v() !== '0) begin
            fails++;
            $display("FAIL mid_reset: got %h, want 0", obs_v());
        end
        rst = 1'b0;
        rq[0] = 1'b1; rq[1] = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            tests++;
            if (obs_v() !== exp_v() || (c == 0 && (gnt_0 !== 1'b1 || gnt_1 !== 1'b0 || dout_valid !== 1'b0))) begin
                fails++;
                $display("FAIL post_reset_tie c%0d: got %h, want %h", c, obs_v(), exp_v());
            end
        end
        quiet_inputs();
    endtask

    task automatic test_random();
        int p = 70;
        do_reset();
        quiet_inputs();
        for (int c = 0; c < 600; c++) begin
            if (c % 100 == 0) p = int'($urandom_range(40, 100));
            rst = ($urandom_range(0, 99) == 0);
            drive_reqs(p, 1, 7, (c >= 300 && c < 400));
            tick();
            tests++;
            if (obs_v() !== exp_v()) begin
                fails++;
                $display("FAIL random c%0d: got %h, want %h", c, obs_v(), exp_v());
            end
        end
        rst = 1'b0;
        quiet_inputs();
    endtask

    initial begin
        rst = 1'b1;
        quiet_inputs();
        test_reset();
        test_single_burst();
        test_round_robin();
        test_burst_limit();
        test_req_drop();
        test_reset_mid_burst();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
